// File: rtl/fusion_stream_out.sv
// fusion_stream_out: output end of the fusion pipeline.
// Tracks which beats in the fixed-latency datapath are real, buffers the
// real beats in a small first-word-fall-through FIFO, and presents them as an
// AXI4-Stream master with per-frame tlast. When the FIFO is full, `stall`
// freezes the upstream pipeline (and the valid tracker) so nothing is lost.
//
// Handshake semantics (both sides):
//   - Output: a beat transfers on every rising edge where m_axis_tvalid and
//     m_axis_tready are both 1. Once tvalid is 1 it stays 1, and tdata/tlast
//     stay unchanged, until that transfer happens. tvalid never depends on
//     tready.
//   - Input: `stall` is the inverse of upstream ready. in_valid is only
//     consumed on an edge where stall is 0. While stall is 1 the whole pipeline,
//     including the tail beat at fused_frame, holds its value.
module fusion_stream_out #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT,
    parameter int PIPE_LATENCY    = 23,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] fused_frame,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done
);

    localparam int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BCNT_W          = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int CNT_W           = PTR_W + 1;
    localparam int ENTRY_W         = DATA_WIDTH + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BCNT = BCNT_W'(BEATS_PER_FRAME - 1);

    // Valid tracker: bit k marks the beat that has spent k+1 unstalled cycles
    // in the datapath; the top bit lines up with fused_frame.
    logic [PIPE_LATENCY-1:0] vsr;

    // Beat position within the current frame.
    logic [BCNT_W-1:0] bcnt;
    logic              beat_last;

    // FIFO storage: each entry is {last, data}.
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    logic push;
    logic pop;

    // Full FIFO freezes upstream; taken from the registered count only.
    assign stall = (count == FULL_CNT);

    // A real beat at the pipeline tail enters the FIFO only on an unstalled
    // cycle, so a tail beat held under stall is written exactly once.
    assign push = ~stall & vsr[PIPE_LATENCY-1];

    assign pop = m_axis_tvalid & m_axis_tready;

    assign beat_last = (bcnt == LAST_BCNT);

    assign head = mem[rd_ptr];

    // Output presentation: head entry when non-empty, zeros otherwise.
    always_comb begin
        m_axis_tvalid = (count != '0);
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = head[DATA_WIDTH-1:0];
            m_axis_tlast = head[DATA_WIDTH];
        end
    end

    // Valid tracker shifts with the datapath and freezes with it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vsr <= '0;
        end else if (!stall) begin
            vsr[0] <= in_valid;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                vsr[k] <= vsr[k-1];
            end
        end
    end

    // Frame beat counter advances on every push and wraps after the last beat.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bcnt <= '0;
        end else if (push) begin
            if (beat_last) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset because count gates the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {beat_last, fused_frame};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One-cycle frame completion pulse after the tlast beat is accepted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & head[DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fusion_stream_out.sv
// Directed bench for fusion_stream_out with a small 4-beat frame and a
// 3-cycle stall-aware pipeline model in front of the block.
module tb_fusion_stream_out;

    localparam int PPB   = 16;
    localparam int IW    = 8;
    localparam int DIM   = 8;
    localparam int DW    = PPB * IW;
    localparam int PL    = 3;
    localparam int DEPTH = 4;
    localparam int BPF   = DIM * DIM / PPB;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] fused_frame;
    logic          stall;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          frame_done;

    logic [DW-1:0] pipe [PL];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // scoreboard state
    logic [DW:0] exp_q[$];
    int  bidx = 0;
    bit  mon_en = 1'b0;
    bit  prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    bit  exp_fd_next = 1'b0;
    int  out_count = 0;
    int  fd_count = 0;
    bit  stall_seen = 1'b0;
    bit  arm = 1'b0;
    int  first_tv_cyc = 0;
    bit  rand_rdy = 1'b0;

    fusion_stream_out #(
        .PIXELS_PER_BEAT(PPB),
        .INPUT_WIDTH(IW),
        .IMAGE_DIM(DIM),
        .DATA_WIDTH(DW),
        .PIPE_LATENCY(PL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .in_valid(in_valid),
        .fused_frame(fused_frame),
        .stall(stall),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // fusion datapath model: delays input data by PL unstalled cycles
    always @(posedge clk) begin
        if (!stall) begin
            pipe[0] <= in_data;
            for (int k = 1; k < PL; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign fused_frame = pipe[PL-1];

    // random ready generator for the AXIS hold phase
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input logic [7:0] tag);
        return {PPB{tag}};
    endfunction

    // present one beat (or bubble) and hold it until an unstalled edge takes it
    task automatic drive_beat(input logic v, input logic [7:0] tag);
        int  guard;
        bit  acc;
        in_valid = v;
        in_data  = beat(tag);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            acc = !stall;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            check("drive_timeout", 0, 1);
        end else if (v) begin
            exp_q.push_back({(bidx == BPF - 1), beat(tag)});
            bidx = (bidx + 1) % BPF;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 600) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 600) check("drain_timeout", exp_q.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // output monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!mon_en) begin
            prev_hold   = 1'b0;
            exp_fd_next = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", m_axis_tlast, prev_last);
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            if (exp_fd_next || frame_done) check("frame_done", frame_done, exp_fd_next);
            if (frame_done) fd_count++;
            exp_fd_next = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {1'b0, m_axis_tdata}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {1'b0, m_axis_tdata}, {1'b0, e[DW-1:0]});
                    check("out_last", m_axis_tlast, e[DW]);
                end
            end
            if (stall) stall_seen = 1'b1;
            if (arm && m_axis_tvalid) begin
                first_tv_cyc = cyc;
                arm = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int base_out;
        int base_fd;

        // reset state
        #3;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_stall", stall, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", {1'b0, m_axis_tdata}, 0);
        check("rst_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;

        // streaming: 8 contiguous beats, tready held high
        stall_seen = 1'b0;
        base_out = out_count;
        base_fd  = fd_count;
        t0  = cyc;
        arm = 1'b1;
        for (int i = 1; i <= 8; i++) drive_beat(1'b1, 8'(i));
        in_valid = 1'b0;
        wait_drain();
        check("stream_latency", first_tv_cyc - t0, PL + 1);
        check("stream_count", out_count - base_out, 8);
        check("stream_frames", fd_count - base_fd, 2);
        check("stream_no_stall", stall_seen, 0);

        // backpressure: FIFO fills with 1-4, 5-7 frozen, 8 held at input
        base_out = out_count;
        base_fd  = fd_count;
        m_axis_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) drive_beat(1'b1, 8'(8'h10 + i));
                in_valid = 1'b0;
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("bp_stall", stall, 1);
                check("bp_tvalid", m_axis_tvalid, 1);
                check("bp_head", {1'b0, m_axis_tdata}, {1'b0, beat(8'h11)});
                check("bp_head_last", m_axis_tlast, 0);
                m_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", out_count - base_out, 8);
        check("bp_frames", fd_count - base_fd, 2);

        // bubbles: valid pattern 1,0,1,1,0,0,1
        base_out = out_count;
        base_fd  = fd_count;
        drive_beat(1'b1, 8'h21);
        drive_beat(1'b0, 8'h22);
        drive_beat(1'b1, 8'h23);
        drive_beat(1'b1, 8'h24);
        drive_beat(1'b0, 8'h25);
        drive_beat(1'b0, 8'h26);
        drive_beat(1'b1, 8'h27);
        in_valid = 1'b0;
        wait_drain();
        check("bub_count", out_count - base_out, 4);
        check("bub_frames", fd_count - base_fd, 1);

        // stall on a tail beat: one pop from full lets exactly the tail in
        base_out = out_count;
        base_fd  = fd_count;
        m_axis_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) drive_beat(1'b1, 8'(8'h30 + i));
                in_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (!stall && g < 50) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check("tail_stall_rise", stall, 1);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("tail_stall_hold", stall, 1);
                end
                check("tail_head", {1'b0, m_axis_tdata}, {1'b0, beat(8'h31)});
                m_axis_tready = 1'b1;
                @(posedge clk);
                #1;
                m_axis_tready = 1'b0;
                check("tail_stall_drop", stall, 0);
                check("tail_head2", {1'b0, m_axis_tdata}, {1'b0, beat(8'h32)});
                @(posedge clk);
                #1;
                check("tail_stall_refill", stall, 1);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                check("tail_head_stable", {1'b0, m_axis_tdata}, {1'b0, beat(8'h32)});
                m_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check("tail_count", out_count - base_out, 8);
        check("tail_frames", fd_count - base_fd, 2);

        // AXIS hold: random tready over 3 frames
        base_out = out_count;
        base_fd  = fd_count;
        rand_rdy = 1'b1;
        for (int i = 1; i <= 12; i++) drive_beat(1'b1, 8'(8'h40 + i));
        in_valid = 1'b0;
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        check("axis_count", out_count - base_out, 12);
        check("axis_frames", fd_count - base_fd, 3);

        // reset mid-frame with two beats buffered
        m_axis_tready = 1'b0;
        drive_beat(1'b1, 8'h61);
        drive_beat(1'b1, 8'h62);
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre_tvalid", m_axis_tvalid, 1);
        mon_en  = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mid_tvalid", m_axis_tvalid, 0);
        check("mid_stall", stall, 0);
        check("mid_tlast", m_axis_tlast, 0);
        check("mid_tdata", {1'b0, m_axis_tdata}, 0);
        check("mid_frame_done", frame_done, 0);
        exp_q.delete();
        bidx = 0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        base_out = out_count;
        base_fd  = fd_count;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) drive_beat(1'b1, 8'(8'h70 + i));
        in_valid = 1'b0;
        wait_drain();
        check("mid_count", out_count - base_out, 4);
        check("mid_frames", fd_count - base_fd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fusion_stream_out.md
# fusion_stream_out

Output end of the fusion pipeline's stall interface: tracks which beats in the fixed-latency fusion datapath are valid. It captures each valid fused beat into a small FIFO, and presents the beats as an AXI4-Stream master with per-frame `tlast`. It generates the `stall` that freezes the upstream pipeline whenever its FIFO is full. It sits between the fusion datapath output and the frame writeback DMA.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per beat.
- `INPUT_WIDTH`, 8, bits per pixel.
- `IMAGE_DIM`, 512, frame is IMAGE_DIM x IMAGE_DIM pixels.
- `DATA_WIDTH`, INPUT_WIDTH*PIXELS_PER_BEAT, beat width.
- `PIPE_LATENCY`, 23, cycles from a beat entering the fusion pipeline to its result at `fused_frame` (counted in non-stalled cycles).
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, >=2.
- `BEATS_PER_FRAME` (localparam), IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT (16384 at defaults).

Ports:
- `clk`  in  1  single clock, rising edge.
- `aresetn`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  beat presented to the fusion pipeline input this cycle is real; sampled only when `stall`=0.
- `fused_frame`  in  DATA_WIDTH  fused pipeline output.
- `stall`  out  1  pipeline freeze; also upstream not-ready.
- `m_axis_tdata`  out  DATA_WIDTH  output beat.
- `m_axis_tvalid`  out  1  FIFO non-empty.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last beat of frame.
- `frame_done`  out  1  one-cycle pulse when a `tlast` beat is accepted downstream.

## Operation
- Valid tracker: PIPE_LATENCY-bit shift register `vsr`. When `stall`=0, `vsr[0]`<=`in_valid` and every `vsr[k]`<=`vsr[k-1]`. When `stall`=1 it holds. `vsr[PIPE_LATENCY-1]` marks `fused_frame` as a real beat.
- Push: when `stall`=0 and `vsr[PIPE_LATENCY-1]`=1, write {last, `fused_frame`} to the FIFO. A tail beat held under stall is pushed exactly once, in the first cycle `stall` drops.
- Beat counter `bcnt`, 0..BEATS_PER_FRAME-1, increments on each push. `last` = (`bcnt`==BEATS_PER_FRAME-1). On that push `bcnt` wraps to 0.
- `stall` = (FIFO count == FIFO_DEPTH), combinational from registered count. No push can occur while full, so there is no overflow by construction.
- Pop: when `m_axis_tvalid` && `m_axis_tready`. Simultaneous push and pop leaves count unchanged. Pop from empty is impossible because tvalid=0.
- `m_axis_tdata`/`m_axis_tlast` come from the FIFO head, first-word fall-through. They stay stable while `tvalid`=1 and `tready`=0 (AXIS rule).
- `frame_done` is registered: it goes high the cycle after a pop of a `tlast` beat.
- Width rules: data is passed through unmodified. Count is log2(FIFO_DEPTH)+1 bits. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset (async assert, sync release) gives: `vsr`=0, FIFO empty, `bcnt`=0, `stall`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `frame_done`=0.
- Reset mid-frame discards all in-flight and buffered beats. The first valid beat after reset starts a new frame at `bcnt`=0.
- Latency: a beat with `in_valid`=1 at cycle t (no stall) is pushed at cycle t+PIPE_LATENCY. `m_axis_tvalid` rises at t+PIPE_LATENCY+1.
- Throughput is 1 beat/cycle with `tready` held high. `stall` never asserts when tready=1 continuously.
- `stall` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop from full.
- Bubbles (`in_valid`=0) propagate through `vsr` and are never pushed. They do not advance `bcnt`.

## Test plan
Test params: IMAGE_DIM=8, PIXELS_PER_BEAT=16 (BEATS_PER_FRAME=4), PIPE_LATENCY=3, FIFO_DEPTH=4. A pipeline model delays the input by 3 unstalled cycles.
- Streaming: tready=1, 8 contiguous valid beats 0x..01..0x..08 -> 8 output beats in order, first tvalid 4 cycles after the first in_valid. tlast on beats 4 and 8. frame_done pulses twice. stall stays 0.
- Backpressure: tready=0 and 8 valid beats -> FIFO fills with beats 1-4, stall=1, beats 5-7 frozen in the pipeline. Then tready=1 -> beats 1-8 emerge exactly once each, no duplicate or drop, tlast on 4 and 8.
- Bubbles: valid pattern 1,0,1,1,0,0,1 with data tags -> exactly 4 output beats with the matching tags. The 4th carries tlast.
- Stall on a tail beat: hold tready=0 so stall rises while the tail valid is 1. Verify the `fused_frame` value held at the tail is pushed once when stall falls.
- AXIS hold: toggle tready randomly for 3 frames -> tdata/tlast stable whenever tvalid=1 and tready=0. 12 beats total, tlast on every 4th.
- Reset mid-frame: after 2 beats of a frame are buffered, pulse aresetn low for 1 cycle -> tvalid=0 immediately, stall=0. The next 4 beats form a full frame with tlast on the 4th.
